// File: rtl/prng_output_buffer.sv
// Buffers 128-bit PRNG words in a small FIFO and serves them as 32-bit slices, requesting PRNG refills when stock runs low.
// Define PRNG_BUF_HEALTH_EN to enable the repetition health check on incoming words.
module prng_output_buffer #(
  parameter int DEPTH      = 4,
  parameter int REFILL_LVL = 1,
  parameter int BURST      = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [127:0]               rnd_i,
  input  logic                       rnd_wr_i,
  input  logic                       flush_i,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [31:0]                rd_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic                       refill_req_o,
  output logic                       health_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  logic [127:0]  mem_q [DEPTH];
  logic [127:0]  headWord;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic full;
  logic empty;
  logic rdXfer;
  logic pop;
  logic repeatHit;
  logic wrAccept;
  logic wrDrop;
  logic refillReq;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign rdXfer = !empty && rd_ready_i && !flush_i;
  assign pop    = rdXfer && (idx_q == 2'd3);

  // A repeated word is discarded before the full rule is even considered.
  assign wrAccept = rnd_wr_i && !flush_i && !repeatHit && (!full || pop);
  assign wrDrop   = rnd_wr_i && !flush_i && !repeatHit && full && !pop;

`ifdef PRNG_BUF_HEALTH_EN
  logic [127:0] held_q;
  logic         heldValid_q;
  logic         healthErr_q;

  assign repeatHit = heldValid_q && (rnd_i == held_q);

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      heldValid_q <= 1'b0;
      healthErr_q <= 1'b0;
    end else begin
      if (rnd_wr_i && repeatHit) begin
        healthErr_q <= 1'b1;
      end
      if (wrAccept) begin
        heldValid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wrAccept) begin
      held_q <= rnd_i;
    end
  end

  assign health_err_o = healthErr_q;
`else
  assign repeatHit    = 1'b0;
  assign health_err_o = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (wrAccept) begin
      mem_q[wrPtr_q] <= rnd_i;
    end
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      level_d    = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      // The 2-bit index wraps from 3 back to 0 on the popping transfer.
      if (rdXfer) begin
        idx_d = idx_q + 2'd1;
        if (pop) begin
          rdPtr_d = rdPtr_q + AW'(1);
        end
      end
      if (wrAccept && !pop) begin
        level_d = level_q + LW'(1);
      end else if (pop && !wrAccept) begin
        level_d = level_q - LW'(1);
      end
      if (wrDrop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    headWord = mem_q[rdPtr_q];
    case (idx_q)
      2'd0:    rd_data_o = headWord[31:0];
      2'd1:    rd_data_o = headWord[63:32];
      2'd2:    rd_data_o = headWord[95:64];
      default: rd_data_o = headWord[127:96];
    endcase
  end

  // WAIT counts every strobe, stored, dropped or discarded, since each one is a word of the run.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    refillReq = (state_q == REQ);
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (int'(level_q) <= REFILL_LVL) begin
            state_d = REQ;
          end
        end
        REQ: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (rnd_wr_i) begin
            if (cnt_q == CW'(BURST - 1)) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_valid_o   = !empty;
  assign level_o      = level_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign overflow_o   = overflow_q;
  assign refill_req_o = refillReq;

endmodule

// File: doc/prng_output_buffer.md
# prng_output_buffer

Downstream stage of the PRNG wrapper. Captures each 128-bit random word on the wrapper's `ctrwrite` strobe into a small FIFO and serves it to the host datapath as 32-bit words over a valid/ready handshake. Also issues refill requests that start a new PRNG run, through the wrapper's `csr[2]` start bit, when stock runs low.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- `DEPTH`, default 4: number of 128-bit entries. Power of two, at least 2.
- `REFILL_LVL`, default 1: request a refill when `level_o <= REFILL_LVL`.
- `BURST`, default 12: words produced by one PRNG run.

**Ports** (name, direction, width, meaning)
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `rnd_i`, in, 128: random word from the PRNG `generatedReg`.
- `rnd_wr_i`, in, 1: capture strobe, driven by PRNG `ctrwrite`.
- `flush_i`, in, 1: discard all stored data and clear status.
- `rd_ready_i`, in, 1: consumer accepts `rd_data_o` this cycle.
- `rd_valid_o`, out, 1: `rd_data_o` holds valid data.
- `rd_data_o`, out, 32: current 32-bit slice of the head entry.
- `level_o`, out, `$clog2(DEPTH)+1`: number of stored 128-bit entries.
- `full_o`, out, 1: asserted when `level_o == DEPTH`.
- `empty_o`, out, 1: asserted when `level_o == 0`.
- `overflow_o`, out, 1: sticky; a write was dropped.
- `refill_req_o`, out, 1: one-cycle start pulse toward the PRNG `csr[2]`.
- `health_err_o`, out, 1: sticky repetition error. Only present behaviour under `PRNG_BUF_HEALTH_EN`; tied 0 otherwise.

## Operation

**Storage**
- Circular FIFO with write pointer, read pointer and level counter.
- A write occurs on `rnd_wr_i` when not full, or when full with a pop in the same cycle.
- A write while full with no pop is dropped and sets `overflow_o`.

**Read side**
- A 2-bit slice index selects `rd_data_o = head[32*idx +: 32]`, least-significant slice first.
- `rd_valid_o = !empty_o`.
- A transfer occurs when `rd_valid_o && rd_ready_i`; the index then increments.
- The transfer at index 3 pops the entry and returns the index to 0.

**Refill FSM**
- States: `IDLE`, `REQ`, `WAIT`.
- `IDLE` → `REQ` when `level_o <= REFILL_LVL`.
- `REQ` drives `refill_req_o` high for exactly one cycle, clears the capture counter, then moves to `WAIT`.
- `WAIT` counts `rnd_wr_i` strobes, including dropped ones, and returns to `IDLE` after `BURST` strobes.
- At most one run is outstanding at a time.

**Flush**
- Empties the FIFO, zeroes the slice index, clears `overflow_o` and `health_err_o`, and returns the FSM to `IDLE`.
- A write or read in the same cycle as `flush_i` is ignored.

**Simultaneous events**
- A write plus a pop in the same cycle leaves `level_o` unchanged.
- `reset` has priority over `flush_i`.
- `flush_i` has priority over all other activity.

## Timing

- **Reset values:** all outputs 0, except `empty_o = 1`. FSM in `IDLE`, pointers and index at 0.
- **Write-to-read latency:** a word written in cycle N into an empty FIFO gives `rd_valid_o = 1` in cycle N+1 with slice 0.
- **Read throughput:** one 32-bit slice per cycle while `rd_ready_i` is held high.
- **Status outputs:** `level_o`, `full_o` and `empty_o` are registered and update the cycle after the write or pop.
- **Refill after reset:** `refill_req_o` pulses in the second cycle after reset deasserts, because level 0 is at or below `REFILL_LVL`.
- **Data stability:** `rd_data_o` must stay stable while `rd_valid_o && !rd_ready_i`.
- **Mid-operation reset:** reset during `WAIT` or during a partial read abandons the run and the partially read entry. Nothing is replayed.

## Configuration

- **`PRNG_BUF_HEALTH_EN` defined:**
  - Holds the last accepted 128-bit word plus a valid flag.
  - An incoming `rnd_i` equal to the held word is discarded, not stored, and sets `health_err_o`.
  - The discarded strobe still counts toward `BURST`.
  - The valid flag is cleared by `reset` or `flush_i`, so the first word after either is never compared.
- **`PRNG_BUF_HEALTH_EN` undefined:**
  - No comparator and no held-word register.
  - `health_err_o` is constant 0.
  - Every strobe is stored, subject only to the full rule.

## Test plan

- **Basic read-out:** after reset, write `0x000000040000000300000002_00000001` with `rd_ready_i = 1`. Read back `0x1`, `0x2`, `0x3`, `0x4` on four consecutive cycles, then `empty_o = 1`.
- **Overflow:** with `DEPTH = 4`, write 5 words with no reads. Expect `full_o = 1`, `level_o = 4`, `overflow_o = 1`, and the 5th word absent on read-out.
- **Refill burst:** from reset, expect a single `refill_req_o` pulse. Then 12 strobes, FSM back in `IDLE`, and no second pulse while `level_o > 1`.
- **Backpressure:** with `rd_ready_i = 0` for 5 cycles mid-entry, `rd_data_o` holds slice 2's value. On release, slices 2 and 3 follow, then the pop.
- **Flush mid-read:** flush after slice 1 of a 3-entry FIFO. Next cycle `level_o = 0` and `overflow_o = 0`, and a new word reads from slice 0.
- **Repetition check (`PRNG_BUF_HEALTH_EN`):** write `A`, `A`, `B`. Expect `level_o = 2`, `health_err_o = 1`, read order `A` then `B`.
